timer_bcd_chain: RTL and testbench

TIMER_BCD_CHAIN -- requirements
Module: timer_bcd_chain

---
 rtl/timer_bcd_chain.sv | 103 ++++++++++
 tb/tb_timer_bcd_chain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_bcd_chain.sv
// Cascadable BCD down-counter with per-digit modulo-6/10 digits, clamped loads,
// optional auto-reload at zero and a one-cycle done pulse on reaching zero.
module timer_bcd_chain #(
  parameter int unsigned          DIGITS   = 4,
  parameter logic [DIGITS-1:0]    SIX_MASK = 4'b0010,
  parameter bit                   WRAP     = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  loadn,
  input  logic                  tick,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   out,
  output logic                  zero,
  output logic                  done,
  output logic                  tc
);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_DEC
  } op_t;

  op_t                 op;
  logic [4*DIGITS-1:0] reload;
  logic [4*DIGITS-1:0] clamped;
  logic [4*DIGITS-1:0] dec;

  function automatic logic [3:0] digit_max(input int unsigned i);
    return SIX_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  always_comb begin
    op = OP_HOLD;
    if (en && !loadn)
      op = OP_LOAD;
    else if (en && tick)
      op = OP_DEC;
  end

  always_comb begin
    clamped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (data[4*i +: 4] > digit_max(i))
        clamped[4*i +: 4] = digit_max(i);
      else
        clamped[4*i +: 4] = data[4*i +: 4];
    end
  end

  // A digit steps only while every lower digit was zero before the step.
  always_comb begin
    logic borrow;
    logic [3:0] cur;
    borrow = 1'b1;
    cur    = '0;
    dec    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      cur = out[4*i +: 4];
      if (!borrow)
        dec[4*i +: 4] = cur;
      else if (cur == 4'd0)
        dec[4*i +: 4] = digit_max(i);
      else
        dec[4*i +: 4] = cur - 4'd1;
      borrow = borrow && (cur == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out    <= '0;
      reload <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (op)
        OP_LOAD: begin
          out    <= clamped;
          reload <= clamped;
          zero   <= (clamped == '0);
        end
        OP_DEC: begin
          if (!zero) begin
            out  <= dec;
            zero <= (dec == '0);
            done <= (dec == '0);
          end else if (WRAP) begin
            out  <= reload;
            zero <= (reload == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign tc = en & loadn & tick & zero;

endmodule

// File: tb/tb_timer_bcd_chain.sv
// Randomized + directed bench for timer_bcd_chain; a hold-at-zero and a wrapping
// instance share stimulus and are checked against a mixed-radix integer model.
module tb_timer_bcd_chain;

  localparam int unsigned DIG  = 4;
  localparam logic [3:0]  MASK = 4'b0010;

  logic        clk = 1'b0;
  logic        clr, en, loadn, tick;
  logic [15:0] data;
  logic [15:0] out0, out1;
  logic        zero0, zero1, done0, done1, tc0, tc1;

  int checks = 0;
  int errors = 0;

  // model state: index 0 = hold at zero, index 1 = wrap
  int unsigned m_n   [2];
  int unsigned m_rel [2];
  bit          m_zero[2];
  bit          m_done[2];

  always #5 clk = ~clk;

  timer_bcd_chain #(.DIGITS(4), .SIX_MASK(4'b0010), .WRAP(1'b0)) dut0 (
    .clk(clk), .clr(clr), .en(en), .loadn(loadn), .tick(tick), .data(data),
    .out(out0), .zero(zero0), .done(done0), .tc(tc0)
  );

  timer_bcd_chain #(.DIGITS(4), .SIX_MASK(4'b0010), .WRAP(1'b1)) dut1 (
    .clk(clk), .clr(clr), .en(en), .loadn(loadn), .tick(tick), .data(data),
    .out(out1), .zero(zero1), .done(done1), .tc(tc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned radix(input int unsigned i);
    return MASK[i] ? 6 : 10;
  endfunction

  // BCD load value -> clamped count as a plain integer
  function automatic int unsigned clamp_val(input logic [15:0] d);
    int unsigned n = 0;
    int unsigned w = 1;
    for (int unsigned i = 0; i < DIG; i++) begin
      int unsigned dg = 32'(d[4*i +: 4]);
      if (dg > radix(i) - 1) dg = radix(i) - 1;
      n += dg * w;
      w *= radix(i);
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned n);
    logic [15:0] v = '0;
    int unsigned r = n;
    for (int unsigned i = 0; i < DIG; i++) begin
      v[4*i +: 4] = 4'(r % radix(i));
      r = r / radix(i);
    end
    return v;
  endfunction

  task automatic model_edge(input bit c, input bit e, input bit ln, input bit t, input logic [15:0] d);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (c) begin
        m_n[k] = 0; m_rel[k] = 0; m_zero[k] = 1'b1;
      end else if (e && !ln) begin
        m_n[k] = clamp_val(d); m_rel[k] = m_n[k]; m_zero[k] = (m_n[k] == 0);
      end else if (e && t) begin
        if (!m_zero[k]) begin
          m_n[k] = m_n[k] - 1;
          m_zero[k] = (m_n[k] == 0);
          m_done[k] = m_zero[k];
        end else if (k == 1) begin
          m_n[k] = m_rel[k];
          m_zero[k] = (m_rel[k] == 0);
        end
      end
    end
  endtask

  task automatic cyc(input bit c, input bit e, input bit ln, input bit t, input logic [15:0] d);
    @(negedge clk);
    clr = c; en = e; loadn = ln; tick = t; data = d;
    #1;
    check("tc0", 32'(tc0), 32'(e & ln & t & m_zero[0]));
    check("tc1", 32'(tc1), 32'(e & ln & t & m_zero[1]));
    @(posedge clk);
    model_edge(c, e, ln, t, d);
    #1;
    check("out0",  32'(out0),  32'(to_bcd(m_n[0])));
    check("zero0", 32'(zero0), 32'(m_zero[0]));
    check("done0", 32'(done0), 32'(m_done[0]));
    check("out1",  32'(out1),  32'(to_bcd(m_n[1])));
    check("zero1", 32'(zero1), 32'(m_zero[1]));
    check("done1", 32'(done1), 32'(m_done[1]));
  endtask

  task automatic load(input logic [15:0] d);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic tk();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; loadn = 1'b1; tick = 1'b0; data = '0;
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_rel[k] = 0; m_zero[k] = 1'b1; m_done[k] = 1'b0;
    end

    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    check("rst_out", 32'(out0), 32'h0);
    check("rst_zero", 32'(zero0), 32'h1);

    // MM:SS countdown across the minute boundary
    load(16'h0130);
    tk();
    check("mmss_first", 32'(out0), 32'h0129);
    repeat (29) tk();
    check("mmss_min", 32'(out0), 32'h0100);
    tk();
    check("mmss_borrow", 32'(out0), 32'h0059);
    check("mmss_zero", 32'(zero0), 32'h0);

    // reaching zero, then ticking while held at zero
    load(16'h0002);
    tk();
    tk();
    check("z_out", 32'(out0), 32'h0);
    check("z_done", 32'(done0), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tk();
      check("z_hold_done", 32'(done0), 32'h0);
      check("z_hold_out", 32'(out0), 32'h0);
    end

    // clamped loads
    load(16'h0099);
    check("clamp99", 32'(out0), 32'h0059);
    load(16'h00FF);
    check("clampFF", 32'(out0), 32'h0059);
    load(16'h0000);
    check("load0_zero", 32'(zero0), 32'h1);
    check("load0_done", 32'(done0), 32'h0);

    // wrapping instance reloads after reaching zero
    load(16'h0001);
    tk();
    check("wrap_done", 32'(done1), 32'h1);
    tk();
    check("wrap_out", 32'(out1), 32'h0001);
    check("wrap_zero", 32'(zero1), 32'h0);
    check("wrap_nodone", 32'(done1), 32'h0);

    // enable gating and load-over-tick priority
    load(16'h1000);
    tk();
    check("borrow3", 32'(out0), 32'h0959);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    check("en_hold", 32'(out0), 32'h0959);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0042);
    check("en_noload", 32'(out0), 32'h0959);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
    check("load_wins", 32'(out0), 32'h0042);

    // clear aborts a running count
    load(16'h0500);
    repeat (3) tk();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0300);
    check("clr_out", 32'(out0), 32'h0);
    check("clr_zero", 32'(zero0), 32'h1);
    repeat (2) tk();
    check("clr_idle", 32'(out0), 32'h0);
    check("clr_idle_wrap", 32'(out1), 32'h0);

    // randomized traffic, biased toward small loads so zero is reached often
    for (int i = 0; i < 2000; i++) begin
      bit          c, e, ln, t;
      logic [15:0] d;
      c  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 9) < 8);
      ln = ($urandom_range(0, 9) != 0);
      t  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 0)
        d = 16'($urandom);
      else
        d = {8'h00, 8'($urandom_range(0, 255) & 8'h1F)};
      cyc(c, e, ln, t, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
